// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package alu_arb_pkg;

   localparam int ALU_DW = 8;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [ALU_DW-1:0] in1;
      logic [ALU_DW-1:0] in2;
      logic [SEL_W-1:0]  s;
      logic              m;
      logic              cin;
   } alu_op_t;

   typedef struct packed {
      logic [ALU_DW-1:0] out;
      logic              cout;
      logic              aeb;
   } alu_res_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and ALU side signal bundle for the arbiter
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*DW-1:0] req_in1;
   logic [NUM_REQ*DW-1:0] req_in2;
   logic [NUM_REQ*4-1:0]  req_s;
   logic [NUM_REQ-1:0]    req_m;
   logic [NUM_REQ-1:0]    req_cin;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [DW-1:0]         rsp_out;
   logic                  rsp_cout;
   logic                  rsp_aeb;
   logic [DW-1:0]         alu_in1;
   logic [DW-1:0]         alu_in2;
   logic [3:0]            alu_s;
   logic                  alu_m;
   logic                  alu_cin;
   logic [DW-1:0]         alu_out;
   logic                  alu_cout;
   logic                  alu_aeb;
   logic                  busy;

   // arbiter side
   modport slave (
      input  req_valid, req_in1, req_in2, req_s, req_m, req_cin, rsp_ready,
      input  alu_out, alu_cout, alu_aeb,
      output req_ready, rsp_valid, rsp_out, rsp_cout, rsp_aeb,
      output alu_in1, alu_in2, alu_s, alu_m, alu_cin, busy
   );

   // requesters plus ALU
   modport master (
      output req_valid, req_in1, req_in2, req_s, req_m, req_cin, rsp_ready,
      output alu_out, alu_cout, alu_aeb,
      input  req_ready, rsp_valid, rsp_out, rsp_cout, rsp_aeb,
      input  alu_in1, alu_in2, alu_s, alu_m, alu_cin, busy
   );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     last_grant_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDW-1:0]     grant_idx_o,
   output logic               any_req_o
);

   // scan from last_grant+1 upward, wrapping, and take the first requester found
   always_comb begin
      int  idx;
      logic found;
      idx         = 0;
      found       = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant_i) + off) % NUM_REQ;
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDW'(idx);
            found        = 1'b1;
         end
      end
      any_req_o = found;
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among requesters
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DW      = ALU_DW,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic           clk,
   input  logic           rst,
   alu_arbiter_if.slave   bus
);

   state_t             state_q;
   logic [IDW-1:0]     last_grant_q;
   logic [IDW-1:0]     grant_q;
   alu_op_t            op_q;
   alu_op_t            op_d;
   alu_res_t           res_q;
   logic [NUM_REQ-1:0] rsp_valid_q;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDW-1:0]     arb_idx;
   logic               arb_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i        (bus.req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .grant_idx_o  (arb_idx),
      .any_req_o    (arb_any)
   );

   // select the winning requester's operands for loading into the ALU registers
   always_comb begin
      op_d     = '0;
      op_d.in1 = bus.req_in1[int'(arb_idx)*DW +: DW];
      op_d.in2 = bus.req_in2[int'(arb_idx)*DW +: DW];
      op_d.s   = bus.req_s[int'(arb_idx)*SEL_W +: SEL_W];
      op_d.m   = bus.req_m[arb_idx];
      op_d.cin = bus.req_cin[arb_idx];
   end

   // operation sequencer: grant in IDLE, let the ALU settle in EXEC, hold the result in RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NUM_REQ-1);
         grant_q      <= '0;
         op_q         <= '0;
         res_q        <= '0;
         rsp_valid_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  op_q    <= op_d;
                  grant_q <= arb_idx;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q.out   <= bus.alu_out;
               res_q.cout  <= bus.alu_cout;
               res_q.aeb   <= bus.alu_aeb;
               rsp_valid_q <= NUM_REQ'(1) << grant_q;
               state_q     <= RESP;
            end
            RESP: begin
               // only the granted requester's ready can retire the response
               if (bus.rsp_ready[grant_q]) begin
                  rsp_valid_q  <= '0;
                  last_grant_q <= grant_q;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= '0;
            end
         endcase
      end
   end

   // the request handshake closes in the same IDLE cycle the grant is made
   assign bus.req_ready = (state_q == IDLE) ? arb_grant : '0;
   assign bus.busy      = (state_q != IDLE);

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_out   = res_q.out;
   assign bus.rsp_cout  = res_q.cout;
   assign bus.rsp_aeb   = res_q.aeb;

   assign bus.alu_in1   = op_q.in1;
   assign bus.alu_in2   = op_q.in2;
   assign bus.alu_s     = op_q.s;
   assign bus.alu_m     = op_q.m;
   assign bus.alu_cin   = op_q.cin;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an adder ALU model
module tb_alu_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   rand_ops = 1'b0;

   typedef struct {
      int         idx;
      logic [7:0] out;
      logic       cout;
      logic       aeb;
   } exp_t;

   exp_t sb_q[$];
   int   grant_log[$];
   int   grant_cyc[$];

   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();

   alu_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
   assign bus.alu_aeb = (bus.alu_in1 == bus.alu_in2);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic rnd_ops();
      for (int i = 0; i < N; i++) begin
         bus.req_in1[i*DW +: DW] = DW'($urandom);
         bus.req_in2[i*DW +: DW] = DW'($urandom);
         bus.req_s[i*4 +: 4]     = 4'($urandom);
         bus.req_m[i]            = 1'($urandom);
         bus.req_cin[i]          = 1'($urandom);
      end
   endtask

   task automatic monitor();
      logic [7:0] a, b;
      logic [8:0] sum;
      exp_t       e;
      for (int i = 0; i < N; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            a   = bus.req_in1[i*DW +: DW];
            b   = bus.req_in2[i*DW +: DW];
            sum = {1'b0, a} + {1'b0, b};
            e.idx = i; e.out = sum[7:0]; e.cout = sum[8]; e.aeb = (a == b);
            sb_q.push_back(e);
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
         end
      end
      if (bus.req_ready != '0)
         check("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
      if (bus.rsp_valid != '0) begin
         check("rsp_valid_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
               if (sb_q.size() == 0) begin
                  check("rsp_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("rsp_idx", i, e.idx);
                  check("rsp_out", 32'(bus.rsp_out), 32'(e.out));
                  check("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
                  check("rsp_aeb", 32'(bus.rsp_aeb), 32'(e.aeb));
               end
            end
         end
      end
   endtask

   // advance to just after the next rising edge; inputs are driven only here
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (rand_ops) rnd_ops();
   endtask

   // observe at the falling edge, away from the active edge
   task automatic sample();
      @(negedge clk);
      if (!rst) monitor();
   endtask

   task automatic clear_logs();
      sb_q.delete();
      grant_log.delete();
      grant_cyc.delete();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic run_until_grants(input int n, input int max_cyc);
      for (int k = 0; k < max_cyc && grant_log.size() < n; k++) begin
         sample();
         tick();
      end
      check("grant_count_reached", 32'(grant_log.size() >= n), 32'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      for (int k = 0; k < 60 && !done; k++) begin
         sample();
         if (!bus.busy && sb_q.size() == 0) done = 1'b1;
         tick();
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      bit seen;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      bus.req_s     = '0;
      bus.req_m     = '0;
      bus.req_cin   = '0;

      // reset state
      sample();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_alu_in1", 32'(bus.alu_in1), 32'd0);
      check("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
      tick();
      rst = 1'b0;

      // single operation, latency and operand registration
      bus.rsp_ready          = '1;
      bus.req_valid          = 4'b0001;
      bus.req_in1[7:0]       = 8'h0F;
      bus.req_in2[7:0]       = 8'h01;
      bus.req_s[3:0]         = 4'h9;
      bus.req_m[0]           = 1'b1;
      bus.req_cin[0]         = 1'b0;
      sample();
      check("t1_req_ready", 32'(bus.req_ready), 32'h1);
      check("t1_busy_idle", 32'(bus.busy), 32'd0);
      tick();
      bus.req_valid = '0;
      sample();
      check("t1_alu_in1", 32'(bus.alu_in1), 32'h0F);
      check("t1_alu_in2", 32'(bus.alu_in2), 32'h01);
      check("t1_alu_s", 32'(bus.alu_s), 32'h9);
      check("t1_alu_m", 32'(bus.alu_m), 32'h1);
      check("t1_busy_exec", 32'(bus.busy), 32'd1);
      check("t1_rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
      tick();
      sample();
      check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("t1_rsp_out", 32'(bus.rsp_out), 32'h10);
      check("t1_rsp_cout", 32'(bus.rsp_cout), 32'd0);
      check("t1_rsp_aeb", 32'(bus.rsp_aeb), 32'd0);
      tick();
      sample();
      check("t1_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
      check("t1_busy_done", 32'(bus.busy), 32'd0);
      tick();

      // all requesting: round-robin order and 3-cycle grant spacing
      reset_dut();
      rand_ops      = 1'b1;
      bus.rsp_ready = '1;
      bus.req_valid = 4'b1111;
      run_until_grants(5, 40);
      if (grant_log.size() >= 5) begin
         check("t2_g0", grant_log[0], 0);
         check("t2_g1", grant_log[1], 1);
         check("t2_g2", grant_log[2], 2);
         check("t2_g3", grant_log[3], 3);
         check("t2_g4", grant_log[4], 0);
         for (int i = 1; i < 5; i++)
            check("t2_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
      end
      drain();

      // response back-pressure on requester 1
      clear_logs();
      bus.rsp_ready = '0;
      bus.req_valid = 4'b0010;
      sample();
      check("t3_req_ready", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = '0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         sample();
         if (bus.rsp_valid[1]) seen = 1'b1;
         else tick();
      end
      check("t3_rsp_seen", 32'(seen), 32'd1);
      tick();
      bus.req_valid = 4'b1101;
      bus.rsp_ready = 4'b1101;
      for (int k = 0; k < 5; k++) begin
         sample();
         check("t3_hold_valid", 32'(bus.rsp_valid), 32'b0010);
         if (sb_q.size() > 0)
            check("t3_hold_out", 32'(bus.rsp_out), 32'(sb_q[0].out));
         check("t3_hold_req_ready", 32'(bus.req_ready), 32'd0);
         check("t3_hold_busy", 32'(bus.busy), 32'd1);
         tick();
      end
      bus.rsp_ready = '1;
      bus.req_valid = '0;
      sample();
      check("t3_release_valid", 32'(bus.rsp_valid), 32'b0010);
      tick();
      sample();
      check("t3_released", 32'(bus.rsp_valid), 32'd0);
      check("t3_idle", 32'(bus.busy), 32'd0);
      tick();
      drain();

      // two continuous requesters alternate
      reset_dut();
      bus.rsp_ready = '1;
      bus.req_valid = 4'b0101;
      run_until_grants(4, 40);
      if (grant_log.size() >= 4) begin
         check("t4_g0", grant_log[0], 0);
         check("t4_g1", grant_log[1], 2);
         check("t4_g2", grant_log[2], 0);
         check("t4_g3", grant_log[3], 2);
      end
      drain();

      // reset while in EXEC drops the operation
      reset_dut();
      rand_ops         = 1'b0;
      bus.rsp_ready    = '1;
      bus.req_in1[7:0] = 8'h5A;
      bus.req_in2[7:0] = 8'h33;
      bus.req_valid    = 4'b0001;
      sample();
      tick();
      bus.req_valid = '0;
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(bus.busy), 32'd0);
      check("t5_rst_alu_in1", 32'(bus.alu_in1), 32'd0);
      check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
      clear_logs();
      tick();
      rst = 1'b0;
      bus.req_valid = 4'b0110;
      sample();
      check("t5_first_grant", 32'(bus.req_ready), 32'b0010);
      check("t5_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
      bus.req_valid = '0;
      drain();

      // all-ones operands: carry out and equality
      clear_logs();
      bus.req_in1[31:24] = 8'hFF;
      bus.req_in2[31:24] = 8'hFF;
      bus.req_valid      = 4'b1000;
      sample();
      tick();
      bus.req_valid = '0;
      sample();
      tick();
      sample();
      check("t6_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
      check("t6_rsp_out", 32'(bus.rsp_out), 32'hFE);
      check("t6_rsp_cout", 32'(bus.rsp_cout), 32'd1);
      check("t6_rsp_aeb", 32'(bus.rsp_aeb), 32'd1);
      tick();
      drain();

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
